pipe_stage_reg: RTL

Parametrised pipeline stage register generalising the fixed ID/EX-style latch: carries an arbitrary control bundle plus data word between two pipeline stages using a valid/ready handshake. Includes a 2-entry skid buffer, so `in_ready` is a registered signal and the stage sustains one transfer per cycle without combinational ready paths. Flush squashes every held entry, and an empty stage presents a configurable bubble (NOP) pattern. Instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB in the next-generation core.

---
 rtl/pipe_stage_reg.sv | 120 ++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline stage register with a 2-entry skid buffer.
// Carries a control bundle and a data word between two pipeline stages.
// in_ready is registered, so there is no combinational path from out_ready.
// Flush empties the stage. While empty, the stage drives a bubble (NOP) pattern.
// Optional feature macro: PIPE_STAGE_PERF_EN adds a saturating stall_cnt output.
//
// Handshake: a transfer happens on a rising edge when valid and ready are both
// high in the cycle before it. valid does not wait for ready. The payload
// stays stable while valid=1 and ready=0.
module pipe_stage_reg #(
    parameter int unsigned            CTRL_W      = 15,
    parameter int unsigned            DATA_W      = 41,
    parameter logic [DATA_W-1:0]      BUBBLE_DATA = DATA_W'({9'b0, 32'h0000_0020}),
    parameter int unsigned            CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    // Main slot drives the outputs. The skid slot catches the entry that
    // arrives while main is stalled.
    logic              main_valid, main_valid_n;
    logic              skid_valid, skid_valid_n;
    logic [CTRL_W-1:0] main_ctrl, main_ctrl_n, skid_ctrl, skid_ctrl_n;
    logic [DATA_W-1:0] main_data, main_data_n, skid_data, skid_data_n;
    logic              in_fire, out_fire;

    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = main_valid & out_ready;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

    // Empty stage presents a NOP: all control enables low, bubble data word.
    assign out_ctrl = main_valid ? main_ctrl : '0;
    assign out_data = main_valid ? main_data : BUBBLE_DATA;

    // Next-state selection for both slots. The stage keeps strict FIFO order.
    always_comb begin
        main_valid_n = main_valid;
        skid_valid_n = skid_valid;
        main_ctrl_n  = main_ctrl;
        main_data_n  = main_data;
        skid_ctrl_n  = skid_ctrl;
        skid_data_n  = skid_data;
        if (!main_valid) begin
            // Skid is never occupied while main is empty.
            if (in_fire) begin
                main_valid_n = 1'b1;
                main_ctrl_n  = in_ctrl;
                main_data_n  = in_data;
            end
        end else if (!skid_valid) begin
            if (out_fire) begin
                main_valid_n = in_fire;
                if (in_fire) begin
                    main_ctrl_n = in_ctrl;
                    main_data_n = in_data;
                end
            end else if (in_fire) begin
                skid_valid_n = 1'b1;
                skid_ctrl_n  = in_ctrl;
                skid_data_n  = in_data;
            end
        end else if (out_fire) begin
            // Skid is full, so in_ready is low and no input can arrive here.
            main_ctrl_n  = skid_ctrl;
            main_data_n  = skid_data;
            skid_valid_n = 1'b0;
        end
    end

    // Valid bits. Reset takes priority over flush, and flush over transfers.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            main_valid <= main_valid_n;
            skid_valid <= skid_valid_n;
        end
    end

    // Payload registers. These are not reset, because outputs are masked by the valid bits.
    always_ff @(posedge clk) begin
        main_ctrl <= main_ctrl_n;
        main_data <= main_data_n;
        skid_ctrl <= skid_ctrl_n;
        skid_data <= skid_data_n;
    end

`ifdef PIPE_STAGE_PERF_EN
    // Count cycles where the head is held by downstream. Saturates; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (main_valid && !out_ready && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    logic [CNT_W-1:0] unused_cnt;
    assign unused_cnt = '0;
`endif

endmodule
